// File: rtl/fsm_rd_sequencer.sv
// fsm_rd_sequencer
// Command-side sequencer for the read/delay/done FSM. It accepts a burst
// command, pulses go, paces each beat with a programmable number of wait
// states on ws, and captures read data on ds into a small output FIFO.
// Each FIFO entry is tagged with a last-beat flag.
// Optional feature: define FSM_RD_SEQ_TIMEOUT_EN to enable a CAPT watchdog
// with a sticky err output.
module fsm_rd_sequencer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 4,
  parameter int WAIT_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [WAIT_W-1:0] cfg_wait,
  output logic              go,
  output logic              ws,
  input  logic              rd,
  input  logic              ds,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef FSM_RD_SEQ_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_CAPT  = 3'd4
  } state_t;

  state_t            state_r;
  logic              cmd_ready_r, go_r, ws_r, busy_r, out_valid_r, out_last_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] out_data_r;
  logic [LEN_W-1:0]  len_r, beat_r;
  logic [WAIT_W-1:0] wait_r, wcnt_r;
  logic [DATA_W-1:0] data_mem_r [0:FIFO_DEPTH-1];
  logic              last_mem_r [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, head_idx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              accept_s, push_s, pop_s, last_s, credit_s, wait_done_s;
  logic              timeout_s, finish_s, active_nxt_s, bypass_s;

`ifdef FSM_RD_SEQ_TIMEOUT_EN
  logic [4:0] wd_r;
  logic       err_r;
  assign err = err_r;
`endif

  assign cmd_ready = cmd_ready_r;
  assign go        = go_r;
  assign ws        = ws_r;
  assign mem_addr  = mem_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;

  // Handshake, credit and FIFO next-state decode shared by the FSM and FIFO
  always_comb begin
    accept_s    = cmd_valid & cmd_ready_r;
    push_s      = (state_r == S_CAPT) & ds;
    pop_s       = out_valid_r & out_ready;
    last_s      = (beat_r == len_r);
    // Only one beat can be outstanding, and none is while in WAIT.
    credit_s    = (cnt_r < CNT_W'(FIFO_DEPTH));
    // The rd cycle that takes the counter to zero already completes the wait.
    wait_done_s = (wcnt_r == {WAIT_W{1'b0}}) | ((wcnt_r == WAIT_W'(1)) & rd);
`ifdef FSM_RD_SEQ_TIMEOUT_EN
    timeout_s   = (state_r == S_CAPT) & ~ds & (wd_r == 5'd15);
`else
    timeout_s   = 1'b0;
`endif
    finish_s    = (push_s & last_s) | timeout_s;
    if (accept_s) begin
      active_nxt_s = 1'b1;
    end else if (finish_s) begin
      active_nxt_s = 1'b0;
    end else begin
      active_nxt_s = (state_r != S_IDLE);
    end
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
    if (pop_s) begin
      head_idx_s = rd_ptr_r + PTR_W'(1);
    end else begin
      head_idx_s = rd_ptr_r;
    end
    // New data becomes the head when the FIFO is (or is becoming) empty.
    bypass_s = push_s & ((cnt_r == {CNT_W{1'b0}}) | ((cnt_r == CNT_W'(1)) & pop_s));
  end

  // Burst sequencing FSM with registered go/ws/cmd_ready/mem_addr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cmd_ready_r <= 1'b0;
      go_r        <= 1'b0;
      ws_r        <= 1'b1;
      mem_addr_r  <= {ADDR_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      beat_r      <= {LEN_W{1'b0}};
      wait_r      <= {WAIT_W{1'b0}};
      wcnt_r      <= {WAIT_W{1'b0}};
`ifdef FSM_RD_SEQ_TIMEOUT_EN
      wd_r        <= 5'd0;
      err_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          ws_r <= 1'b1;
          if (accept_s) begin
            state_r     <= S_START;
            cmd_ready_r <= 1'b0;
            go_r        <= 1'b1;
            mem_addr_r  <= cmd_addr;
            len_r       <= cmd_len;
            wait_r      <= cfg_wait;
            beat_r      <= {LEN_W{1'b0}};
          end else begin
            cmd_ready_r <= 1'b1;
            go_r        <= 1'b0;
          end
        end
        S_START: begin
          go_r    <= 1'b0;
          wcnt_r  <= wait_r;
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_done_s && credit_s) begin
            state_r <= S_ISSUE;
            ws_r    <= 1'b0;
          end else if (rd && (wcnt_r != {WAIT_W{1'b0}})) begin
            wcnt_r <= wcnt_r - WAIT_W'(1);
          end
        end
        S_ISSUE: begin
          if (rd) begin
            state_r <= S_CAPT;
            ws_r    <= 1'b1;
`ifdef FSM_RD_SEQ_TIMEOUT_EN
            wd_r    <= 5'd0;
`endif
          end
        end
        S_CAPT: begin
          if (ds) begin
            beat_r     <= beat_r + LEN_W'(1);
            mem_addr_r <= mem_addr_r + ADDR_W'(1);
            wcnt_r     <= wait_r;
            if (last_s) begin
              state_r     <= S_IDLE;
              cmd_ready_r <= 1'b1;
            end else begin
              state_r <= S_WAIT;
            end
          end else if (timeout_s) begin
            // Abandon the burst; the pending beat is never pushed.
            state_r     <= S_IDLE;
            cmd_ready_r <= 1'b1;
`ifdef FSM_RD_SEQ_TIMEOUT_EN
            err_r       <= 1'b1;
`endif
          end else begin
`ifdef FSM_RD_SEQ_TIMEOUT_EN
            wd_r <= wd_r + 5'd1;
`endif
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cmd_ready_r <= 1'b0;
          go_r        <= 1'b0;
          ws_r        <= 1'b1;
        end
      endcase
    end
  end

  // Output FIFO storage, pointers and registered head/valid/busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_r[i] <= {DATA_W{1'b0}};
        last_mem_r[i] <= 1'b0;
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= mem_rdata;
        last_mem_r[wr_ptr_r] <= last_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r    <= head_idx_s;
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= (cnt_nxt_s != {CNT_W{1'b0}});
      busy_r      <= active_nxt_s | (cnt_nxt_s != {CNT_W{1'b0}});
      if (bypass_s) begin
        out_data_r <= mem_rdata;
        out_last_r <= last_s;
      end else begin
        out_data_r <= data_mem_r[head_idx_s];
        out_last_r <= last_mem_r[head_idx_s];
      end
    end
  end

endmodule

// File: tb/tb_fsm_rd_sequencer.sv
// tb_fsm_rd_sequencer
// Directed bench for fsm_rd_sequencer. A small responder plays the
// read/delay/done FSM: it raises rd after go, issues on rd & !ws, and returns
// data {8'h5A, issued address} on ds. Inputs change 1ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_fsm_rd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cfg_wait;
  logic        go, ws, rd, ds;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        out_valid, out_ready, out_last, busy;
  logic [15:0] out_data;
`ifdef FSM_RD_SEQ_TIMEOUT_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // responder state
  int         phase = 0;
  int         dly = 0;
  int         ds_delay = 0;
  int         burst_beats = 1;
  int         beats_done = 0;
  logic [7:0] iss_addr = 8'h00;
  logic       last_ds = 1'b0;

  // monitor state
  int          rdws = 0;
  logic [7:0]  iss_q[$];
  int          cnt_q[$];
  logic [16:0] out_q[$];

  fsm_rd_sequencer #(
    .DATA_W(16), .ADDR_W(8), .LEN_W(4), .WAIT_W(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cfg_wait(cfg_wait),
    .go(go), .ws(ws), .rd(rd), .ds(ds),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
`ifdef FSM_RD_SEQ_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // responder modelling the downstream read FSM
  initial begin
    rd = 1'b0;
    ds = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        phase = 0; rd = 1'b0; ds = 1'b0; last_ds = 1'b0;
      end else begin
        case (phase)
          0: begin
            rd = 1'b0; ds = 1'b0; last_ds = 1'b0;
            if (go) begin
              phase = 1;
              beats_done = 0;
            end
          end
          1: begin
            rd = 1'b1; ds = 1'b0; last_ds = 1'b0;
            if (!ws) begin
              iss_addr = mem_addr;
              phase = 2;
              dly = ds_delay;
            end
          end
          2: begin
            rd = 1'b0;
            if (dly == 0) begin
              ds = 1'b1;
              mem_rdata = {8'h5A, iss_addr};
              beats_done++;
              last_ds = (beats_done == burst_beats);
              phase = last_ds ? 0 : 1;
            end else begin
              dly--;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // monitor: issues, pops, output hold and capture-to-valid timing
  initial begin
    logic        hold_v, prev_ds, prev_ov, prev_last;
    logic [16:0] hold_d;
    hold_v = 1'b0; prev_ds = 1'b0; prev_ov = 1'b0; prev_last = 1'b0; hold_d = 17'h0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_ds && !prev_ov && ds_delay == 0) chk("ov_after_ds", 32'(out_valid), 32'd1);
        if (prev_ds && prev_last) chk("rdy_after_last", 32'(cmd_ready), 32'd1);
        if (hold_v && out_valid) chk("head_hold", 32'({out_last, out_data}), 32'(hold_d));
        if (go) rdws = 0;
        if (rd && ws) rdws++;
        if (rd && !ws) begin
          iss_q.push_back(mem_addr);
          cnt_q.push_back(rdws);
          rdws = 0;
        end
        if (out_valid && out_ready) out_q.push_back({out_last, out_data});
        hold_v = out_valid && !out_ready;
        hold_d = {out_last, out_data};
        prev_ds = ds; prev_ov = out_valid; prev_last = last_ds;
      end else begin
        hold_v = 1'b0; prev_ds = 1'b0; prev_ov = 1'b0; prev_last = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] a, input logic [3:0] l, input logic [2:0] w);
    burst_beats = int'(l) + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cfg_wait = w;
    @(negedge clk);
    chk("rdy_at_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("go_pulse", 32'(go), 32'd1);
    chk("rdy_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("go_single", 32'(go), 32'd0);
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (k < max && (busy || !cmd_ready || phase != 0)) begin
      @(negedge clk);
      k++;
    end
    chk("done_in_time", 32'(k < max), 32'd1);
  endtask

  task automatic check_burst(input logic [7:0] base, input int beats, input int exp_rdws);
    logic [7:0] a;
    chk("n_issue", 32'(iss_q.size()), 32'(beats));
    chk("n_out", 32'(out_q.size()), 32'(beats));
    for (int i = 0; i < beats; i++) begin
      a = base + 8'(i);
      chk("beat_addr", 32'(iss_q[i]), 32'(a));
      chk("beat_data", 32'(out_q[i]), 32'({(i == beats - 1), 8'h5A, a}));
      if (exp_rdws >= 0) chk("wait_rd_cycles", 32'(cnt_q[i]), 32'(exp_rdws));
    end
    iss_q.delete(); cnt_q.delete(); out_q.delete();
  endtask

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  // directed test sequence
  initial begin
    int k;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_len = 4'h0;
    cfg_wait = 3'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_ws", 32'(ws), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rdy_after_reset", 32'(cmd_ready), 32'd1);

    // single beat
    send_cmd(8'h10, 4'd0, 3'd0);
    wait_done(50);
    check_burst(8'h10, 1, -1);

    // burst with two wait states per beat
    send_cmd(8'h20, 4'd3, 3'd2);
    wait_done(200);
    check_burst(8'h20, 4, 2);

    // backpressure: FIFO fills after four beats
    @(posedge clk); #1; out_ready = 1'b0;
    send_cmd(8'h40, 4'd7, 3'd0);
    repeat (40) @(negedge clk);
    chk("bp_ws_held", 32'(ws), 32'd1);
    chk("bp_issued", 32'(iss_q.size()), 32'd4);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_data", 32'(out_data), 32'h5A40);
    chk("bp_head_last", 32'(out_last), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    @(posedge clk); #1; out_ready = 1'b1;
    wait_done(300);
    check_burst(8'h40, 8, -1);

    // address wrap
    send_cmd(8'hFE, 4'd3, 3'd1);
    wait_done(200);
    check_burst(8'hFE, 4, 1);

    // reset mid-burst after the second capture
    @(posedge clk); #1; out_ready = 1'b0;
    send_cmd(8'h60, 4'd5, 3'd0);
    k = 0;
    while (k < 100 && beats_done < 2) begin
      @(negedge clk);
      k++;
    end
    chk("second_ds_seen", 32'(k < 100), 32'd1);
    @(posedge clk); #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ws", 32'(ws), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    iss_q.delete(); cnt_q.delete(); out_q.delete();
    @(negedge clk); @(negedge clk);
    chk("rdy_after_mid_rst", 32'(cmd_ready), 32'd1);
    send_cmd(8'h70, 4'd0, 3'd0);
    wait_done(50);
    check_burst(8'h70, 1, -1);

`ifdef FSM_RD_SEQ_TIMEOUT_EN
    // watchdog: ds withheld beyond the CAPT limit
    ds_delay = 20;
    send_cmd(8'h80, 4'd0, 3'd0);
    k = 0;
    while (k < 40 && !err) begin
      @(negedge clk);
      k++;
    end
    chk("wd_err", 32'(err), 32'd1);
    repeat (30) @(negedge clk);
    chk("wd_idle_ready", 32'(cmd_ready), 32'd1);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_no_output", 32'(out_q.size()), 32'd0);
    chk("wd_err_sticky", 32'(err), 32'd1);
    ds_delay = 0;
    iss_q.delete(); cnt_q.delete(); out_q.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
